top_soc: RTL and testbench

Top-level SoC shell for the yaricv32 bring-up image. It streams a fixed 16-byte boot banner out of an internal byte ROM over a UART transmitter (8N1, LSB first), then holds the line idle. `uart_tx` is its only output. It is the top of the FPGA/simulation hierarchy, so the bit period is parameterised to keep simulation runs short.

---
 rtl/top_soc.sv | 142 ++++++++++++++
 tb/tb_top_soc.sv | 121 ++++++++++++
 2 files changed

// File: rtl/top_soc.sv
// Boot-banner SoC shell: streams a fixed 16-byte ROM message over an 8N1 UART
// transmitter once after reset, then holds the line idle-high.
module top_soc #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned MSG_LEN      = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic uart_tx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_q, tx_d;

  logic [7:0]    cur_byte;
  logic [2:0]    next_bit;
  logic          period_end;

  function automatic logic [7:0] rom_byte(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'h48;
      4'd1:    b = 8'h65;
      4'd2:    b = 8'h6C;
      4'd3:    b = 8'h6C;
      4'd4:    b = 8'h6F;
      4'd5:    b = 8'h2C;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h52;
      4'd8:    b = 8'h49;
      4'd9:    b = 8'h53;
      4'd10:   b = 8'h43;
      4'd11:   b = 8'h2D;
      4'd12:   b = 8'h56;
      4'd13:   b = 8'h21;
      4'd14:   b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign cur_byte   = rom_byte(idx_q);
  assign next_bit   = bit_q + 3'd1;
  assign period_end = (cnt_q == CNT_LAST);

  // tx_d is the level for the *next* bit period, so the line only moves on
  // the edge that starts a new bit and the output stays a plain flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        state_d = START;
        cnt_d   = '0;
        tx_d    = 1'b0;
      end
      START: begin
        if (period_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (period_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = next_bit;
            tx_d  = cur_byte[next_bit];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (period_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        tx_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_top_soc.sv
// Directed bench for top_soc: cycle-exact UART waveform check plus byte decode,
// covering reset hold, full banner, idle tail, mid-frame reset and 1-clock bits.
module tb_top_soc;

  logic clk = 1'b0;
  logic rst_n;
  logic rst1_n;
  logic tx0;
  logic tx1;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] EXP [16] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h52,
    8'h49, 8'h53, 8'h43, 8'h2D, 8'h56, 8'h21, 8'h0D, 8'h0A
  };

  always #2 clk = ~clk;

  top_soc u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_tx (tx0)
  );

  top_soc #(.CLKS_PER_BIT(1)) u_dut_fast (
    .clk     (clk),
    .rst_n   (rst1_n),
    .uart_tx (tx1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Caller releases reset on a falling edge; sample i is taken 1ns after edge E0+i.
  task automatic run_banner(input bit sel, input int c, input int limit, input string tag);
    int k;
    logic [7:0] rx;
    logic exp_bit;
    logic cur;
    k = 0;
    for (int n = 0; n < 16; n++) begin
      rx = '0;
      for (int s = 0; s < 10; s++) begin
        if (s == 0)      exp_bit = 1'b0;
        else if (s == 9) exp_bit = 1'b1;
        else             exp_bit = EXP[n][s-1];
        for (int j = 0; j < c; j++) begin
          if (k >= limit) return;
          tick();
          cur = sel ? tx1 : tx0;
          chk($sformatf("%s_byte%0d_slot%0d_cyc%0d", tag, n, s, j), {7'd0, cur}, {7'd0, exp_bit});
          if (j == c / 2 && s >= 1 && s <= 8) rx[s-1] = cur;
          k++;
        end
      end
      chk($sformatf("%s_rx_byte%0d", tag, n), rx, EXP[n]);
    end
  endtask

  task automatic idle_high(input bit sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s_%0d", tag, i), {7'd0, (sel ? tx1 : tx0)}, 8'd1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst1_n = 1'b0;

    // Reset held for 10 cycles: line idle-high throughout.
    idle_high(1'b0, 10, "reset_hold");

    // Release, full banner at 4 clocks/bit, then idle tail to 875 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    run_banner(1'b0, 4, 640, "banner");
    idle_high(1'b0, 235, "done_idle");
    chk("fast_held_in_reset", {7'd0, tx1}, 8'd1);

    // Restart, then reset inside byte 3 data bit 4 (cycles E0+140..143, bit = 0).
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("rerun_reset", {7'd0, tx0}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_banner(1'b0, 4, 142, "pre_abort");
    rst_n = 1'b0;
    #1;
    chk("async_reset_high", {7'd0, tx0}, 8'd1);
    idle_high(1'b0, 2, "abort_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_banner(1'b0, 4, 640, "restart");
    idle_high(1'b0, 20, "restart_idle");
    chk("fast_never_started", {7'd0, tx1}, 8'd1);

    // One clock per bit: 10-cycle frames, 160-cycle banner.
    @(negedge clk);
    rst1_n = 1'b1;
    run_banner(1'b1, 1, 160, "fast");
    idle_high(1'b1, 20, "fast_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
